// File: rtl/reduce_ring_pkg.sv
// reduce_ring_pkg: shared state encodings, default widths and register map for the reduce_ring node.
// Contents:
//   state_t              arbiter FSM states (IDLE, HDR, PAYLOAD)
//   DEF_DATA_WIDTH       default datapath word width
//   DEF_CTRL_WIDTH       default ctrl width
//   UDP_REG_ADDR_WIDTH   register ring address width
//   CPCI_NF2_DATA_WIDTH  register ring data width
//   RIA_PKT_CNT_ADDR     address of the input arbiter packet counter
package reduce_ring_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2
   } state_t;
   localparam int DEF_DATA_WIDTH      = 64;
   localparam int DEF_CTRL_WIDTH      = 8;
   localparam int UDP_REG_ADDR_WIDTH  = 23;
   localparam int CPCI_NF2_DATA_WIDTH = 32;
   localparam logic [UDP_REG_ADDR_WIDTH-1:0] RIA_PKT_CNT_ADDR = '0;
endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin pick of the next requesting queue after the last one served.
// Ports:
//   i_req    per-queue request vector
//   i_last   index of the queue granted most recently
//   o_grant  first requesting index searching from i_last+1 (wrapping); i_last if none requests
module rr_grant #(
   parameter int NUM_QUEUES = 4,
   localparam int IW = $clog2(NUM_QUEUES)
) (
   input  logic [NUM_QUEUES-1:0] i_req,
   input  logic [IW-1:0]         i_last,
   output logic [IW-1:0]         o_grant
);
   logic [IW-1:0] w_idx;
   // Walk from the farthest offset down to the nearest so the closest requester overwrites the rest.
   always_comb begin
      o_grant = i_last;
      w_idx = i_last;
      for (int k = NUM_QUEUES; k >= 1; k--) begin
         w_idx = IW'((int'(i_last) + k) % NUM_QUEUES);
         if (i_req[w_idx]) o_grant = w_idx;
      end
   end
endmodule

// File: rtl/reduce_input_arbiter.sv
// reduce_input_arbiter: packet-granular round-robin merge of NUM_QUEUES queues onto one registered stream.
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_in_data/i_in_ctrl/i_in_wr    packed per-queue words and valids (queue i at slice i)
//   o_in_rdy                       per-queue accept, combinational from i_out_rdy
//   o_out_data/o_out_ctrl/o_out_wr registered output word towards output_port_lookup
//   i_out_rdy                      downstream can take a word
//   i_reg_*_in / o_reg_*_out       register ring stage; serves the read-only packet counter
module reduce_input_arbiter
   import reduce_ring_pkg::*;
#(
   parameter int NUM_QUEUES        = 4,
   parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
   parameter int CTRL_WIDTH        = DEF_CTRL_WIDTH,
   parameter int UDP_REG_SRC_WIDTH = 2,
   parameter logic [UDP_REG_ADDR_WIDTH-1:0] PKT_CNT_ADDR = RIA_PKT_CNT_ADDR
) (
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic [NUM_QUEUES*DATA_WIDTH-1:0] i_in_data,
   input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] i_in_ctrl,
   input  logic [NUM_QUEUES-1:0]            i_in_wr,
   output logic [NUM_QUEUES-1:0]            o_in_rdy,
   output logic [DATA_WIDTH-1:0]            o_out_data,
   output logic [CTRL_WIDTH-1:0]            o_out_ctrl,
   output logic                             o_out_wr,
   input  logic                             i_out_rdy,
   input  logic                             i_reg_req_in,
   input  logic                             i_reg_ack_in,
   input  logic                             i_reg_rd_wr_L_in,
   input  logic [UDP_REG_ADDR_WIDTH-1:0]    i_reg_addr_in,
   input  logic [CPCI_NF2_DATA_WIDTH-1:0]   i_reg_data_in,
   input  logic [UDP_REG_SRC_WIDTH-1:0]     i_reg_src_in,
   output logic                             o_reg_req_out,
   output logic                             o_reg_ack_out,
   output logic                             o_reg_rd_wr_L_out,
   output logic [UDP_REG_ADDR_WIDTH-1:0]    o_reg_addr_out,
   output logic [CPCI_NF2_DATA_WIDTH-1:0]   o_reg_data_out,
   output logic [UDP_REG_SRC_WIDTH-1:0]     o_reg_src_out
);
   localparam int IW = $clog2(NUM_QUEUES);
   localparam int RW = CPCI_NF2_DATA_WIDTH;

   state_t                  r_state, w_state_nxt;
   logic [IW-1:0]           r_cur, r_last, w_grant;
   logic [RW-1:0]           r_pkt_cnt;
   logic [DATA_WIDTH-1:0]   r_out_data, w_data;
   logic [CTRL_WIDTH-1:0]   r_out_ctrl, w_ctrl;
   logic                    r_out_wr, w_xfer, w_eop, w_hit;
   logic                    r_reg_req, r_reg_ack, r_reg_rd_wr_L;
   logic [UDP_REG_ADDR_WIDTH-1:0] r_reg_addr;
   logic [RW-1:0]           r_reg_data;
   logic [UDP_REG_SRC_WIDTH-1:0]  r_reg_src;

   rr_grant #(.NUM_QUEUES(NUM_QUEUES)) u_grant (
      .i_req   (i_in_wr),
      .i_last  (r_last),
      .o_grant (w_grant)
   );

   assign w_data   = i_in_data[r_cur*DATA_WIDTH +: DATA_WIDTH];
   assign w_ctrl   = i_in_ctrl[r_cur*CTRL_WIDTH +: CTRL_WIDTH];
   assign w_xfer   = (r_state != IDLE) && i_out_rdy && i_in_wr[r_cur];
   // EOP is the first non-zero ctrl after the payload has started; header words also carry non-zero ctrl.
   assign w_eop    = w_xfer && (r_state == PAYLOAD) && (w_ctrl != '0);
   assign w_hit    = i_reg_req_in && !i_reg_ack_in && (i_reg_addr_in == PKT_CNT_ADDR);
   assign o_in_rdy = ((r_state != IDLE) && i_out_rdy) ? (NUM_QUEUES'(1) << r_cur) : '0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (|i_in_wr) w_state_nxt = HDR;
         HDR:     if (w_xfer && w_ctrl == '0) w_state_nxt = PAYLOAD;
         PAYLOAD: if (w_xfer && w_ctrl != '0) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= IDLE;
         r_cur         <= '0;
         r_last        <= IW'(NUM_QUEUES - 1);
         r_pkt_cnt     <= '0;
         r_out_wr      <= 1'b0;
         r_out_data    <= '0;
         r_out_ctrl    <= '0;
         r_reg_req     <= 1'b0;
         r_reg_ack     <= 1'b0;
         r_reg_rd_wr_L <= 1'b0;
         r_reg_addr    <= '0;
         r_reg_data    <= '0;
         r_reg_src     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && |i_in_wr) r_cur <= w_grant;
         if (w_eop) r_last <= r_cur;
         r_pkt_cnt <= r_pkt_cnt + RW'(w_eop);
         r_out_wr  <= w_xfer;
         if (w_xfer) begin
            r_out_data <= w_data;
            r_out_ctrl <= w_ctrl;
         end
         r_reg_req     <= i_reg_req_in;
         r_reg_ack     <= i_reg_ack_in | w_hit;
         r_reg_rd_wr_L <= i_reg_rd_wr_L_in;
         r_reg_addr    <= i_reg_addr_in;
         // Reads see the count before any EOP landing in this same cycle.
         r_reg_data    <= (w_hit && i_reg_rd_wr_L_in) ? r_pkt_cnt : i_reg_data_in;
         r_reg_src     <= i_reg_src_in;
      end
   end

   assign o_out_data        = r_out_data;
   assign o_out_ctrl        = r_out_ctrl;
   assign o_out_wr          = r_out_wr;
   assign o_reg_req_out     = r_reg_req;
   assign o_reg_ack_out     = r_reg_ack;
   assign o_reg_rd_wr_L_out = r_reg_rd_wr_L;
   assign o_reg_addr_out    = r_reg_addr;
   assign o_reg_data_out    = r_reg_data;
   assign o_reg_src_out     = r_reg_src;
endmodule

// File: tb/tb_reduce_input_arbiter.sv
// tb_reduce_input_arbiter: randomized self-checking bench with a packet-level reference model.
module tb_reduce_input_arbiter;
   import reduce_ring_pkg::*;
   localparam int N  = 4;
   localparam int DW = 64;
   localparam int CW = 8;
   localparam int AW = UDP_REG_ADDR_WIDTH;
   localparam int RW = CPCI_NF2_DATA_WIDTH;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [N*DW-1:0] in_data = '0;
   logic [N*CW-1:0] in_ctrl = '0;
   logic [N-1:0]    in_wr = '0;
   logic [N-1:0]    in_rdy;
   logic [DW-1:0]   out_data;
   logic [CW-1:0]   out_ctrl;
   logic            out_wr;
   logic            out_rdy = 1'b1;
   logic            reg_req = 1'b0, reg_ack = 1'b0, reg_rw = 1'b0;
   logic [AW-1:0]   reg_addr = '0;
   logic [RW-1:0]   reg_data = '0;
   logic [SW-1:0]   reg_src = '0;
   logic            reg_req_o, reg_ack_o, reg_rw_o;
   logic [AW-1:0]   reg_addr_o;
   logic [RW-1:0]   reg_data_o;
   logic [SW-1:0]   reg_src_o;

   always #5 clk = ~clk;

   reduce_input_arbiter #(.NUM_QUEUES(N)) dut (
      .i_clk             (clk),
      .i_reset           (reset),
      .i_in_data         (in_data),
      .i_in_ctrl         (in_ctrl),
      .i_in_wr           (in_wr),
      .o_in_rdy          (in_rdy),
      .o_out_data        (out_data),
      .o_out_ctrl        (out_ctrl),
      .o_out_wr          (out_wr),
      .i_out_rdy         (out_rdy),
      .i_reg_req_in      (reg_req),
      .i_reg_ack_in      (reg_ack),
      .i_reg_rd_wr_L_in  (reg_rw),
      .i_reg_addr_in     (reg_addr),
      .i_reg_data_in     (reg_data),
      .i_reg_src_in      (reg_src),
      .o_reg_req_out     (reg_req_o),
      .o_reg_ack_out     (reg_ack_o),
      .o_reg_rd_wr_L_out (reg_rw_o),
      .o_reg_addr_out    (reg_addr_o),
      .o_reg_data_out    (reg_data_o),
      .o_reg_src_out     (reg_src_o)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int seq     = 0;

   logic [DW-1:0] q_data[N][$];
   logic [CW-1:0] q_ctrl[N][$];
   int            q_len[N][$];

   int            m_cur  = -1;
   int            m_last = N - 1;
   int            m_rem  = 0;
   logic [RW-1:0] m_cnt  = '0;

   logic          e_wr = 1'b0;
   logic [DW-1:0] e_data = '0;
   logic [CW-1:0] e_ctrl = '0;
   logic          e_rreq = 1'b0, e_rack = 1'b0, e_rrw = 1'b0;
   logic [AW-1:0] e_raddr = '0;
   logic [RW-1:0] e_rdata = '0;
   logic [SW-1:0] e_rsrc = '0;

   bit bubbles  = 1'b0;
   bit rdy_rand = 1'b0;
   int stall    = 0;
   bit rd_cnt   = 1'b0;
   bit do_rst   = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic add_pkt(input int q, input int len, input int h, input logic [CW-1:0] eop);
      seq++;
      for (int w = 0; w < len; w++) begin
         q_data[q].push_back({8'(q), 24'(seq), 32'($urandom)});
         q_ctrl[q].push_back(w == len - 1 ? eop : w == 0 ? 8'hFF : w < h ? 8'($urandom_range(1, 255)) : 8'h00);
      end
      q_len[q].push_back(len);
   endtask

   task automatic add_rand_pkt(input int q);
      int len;
      len = $urandom_range(3, 9);
      add_pkt(q, len, len > 3 ? 1 + int'($urandom % 2) : 1, 8'(1 << $urandom_range(0, 7)));
   endtask

   task automatic step();
      logic [N-1:0] wr;
      logic         ordy, hit;
      bit           found;
      @(negedge clk);
      chk("out_wr", {63'b0, out_wr}, {63'b0, e_wr});
      if (e_wr) begin
         chk("out_data", out_data, e_data);
         chk("out_ctrl", {56'b0, out_ctrl}, {56'b0, e_ctrl});
      end
      chk("reg_req_out", {63'b0, reg_req_o}, {63'b0, e_rreq});
      chk("reg_ack_out", {63'b0, reg_ack_o}, {63'b0, e_rack});
      chk("reg_rw_out", {63'b0, reg_rw_o}, {63'b0, e_rrw});
      chk("reg_addr_out", 64'(reg_addr_o), 64'(e_raddr));
      chk("reg_data_out", 64'(reg_data_o), 64'(e_rdata));
      chk("reg_src_out", 64'(reg_src_o), 64'(e_rsrc));
      ordy = (stall > 0) ? 1'b0 : rdy_rand ? ($urandom % 4 != 0) : 1'b1;
      if (stall > 0) stall--;
      for (int i = 0; i < N; i++) begin
         wr[i] = !do_rst && q_data[i].size() != 0 && !(bubbles && $urandom % 8 == 0);
         in_data[i*DW +: DW] = q_data[i].size() != 0 ? q_data[i][0] : '0;
         in_ctrl[i*CW +: CW] = q_ctrl[i].size() != 0 ? q_ctrl[i][0] : '0;
      end
      in_wr = wr;
      out_rdy = ordy;
      if (rd_cnt) begin
         reg_req = 1'b1; reg_ack = 1'b0; reg_rw = 1'b1; reg_addr = RIA_PKT_CNT_ADDR;
      end else begin
         reg_req = 1'($urandom); reg_ack = ($urandom % 4 == 0); reg_rw = 1'($urandom);
         reg_addr = ($urandom % 3 == 0) ? RIA_PKT_CNT_ADDR : AW'($urandom);
      end
      reg_data = RW'($urandom);
      reg_src = SW'($urandom);
      reset = do_rst;
      #1;
      chk("in_rdy", 64'(in_rdy), (m_cur >= 0 && ordy) ? 64'(1) << m_cur : 64'(0));
      rd_cnt = 1'b0;
      if (do_rst) begin
         for (int i = 0; i < N; i++) begin
            q_data[i].delete(); q_ctrl[i].delete(); q_len[i].delete();
         end
         m_cur = -1; m_last = N - 1; m_rem = 0; m_cnt = '0;
         e_wr = 0; e_data = '0; e_ctrl = '0;
         e_rreq = 0; e_rack = 0; e_rrw = 0; e_raddr = '0; e_rdata = '0; e_rsrc = '0;
         do_rst = 1'b0;
         return;
      end
      hit = reg_req && !reg_ack && reg_addr == RIA_PKT_CNT_ADDR;
      e_rreq = reg_req; e_rack = reg_ack | hit; e_rrw = reg_rw;
      e_raddr = reg_addr; e_rsrc = reg_src;
      e_rdata = (hit && reg_rw) ? m_cnt : reg_data;
      e_wr = 1'b0;
      if (m_cur < 0) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (!found && wr[idx]) begin
               found = 1'b1;
               m_cur = idx;
               m_rem = q_len[idx].pop_front();
            end
         end
      end else if (ordy && wr[m_cur]) begin
         e_wr = 1'b1;
         e_data = q_data[m_cur].pop_front();
         e_ctrl = q_ctrl[m_cur].pop_front();
         m_rem--;
         if (m_rem == 0) begin
            m_last = m_cur;
            m_cur = -1;
            m_cnt++;
         end
      end
   endtask

   function automatic bit busy();
      bit b;
      b = m_cur >= 0;
      for (int i = 0; i < N; i++) b |= q_data[i].size() != 0;
      return b;
   endfunction

   task automatic drain();
      int c;
      c = 0;
      while (busy() && c < 3000) begin
         step();
         c++;
      end
      if (c >= 3000) chk("drain_timeout", 64'(c), 64'(0));
      step();
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      step();
      // single packet, queue 0
      add_pkt(0, 4, 1, 8'h04);
      drain();
      rd_cnt = 1'b1;
      step();
      step();
      // four simultaneous 3-word packets
      for (int q = 0; q < N; q++) add_pkt(q, 3, 1, 8'(1 << q));
      drain();
      // out_rdy stall mid-payload
      add_pkt(2, 10, 2, 8'hF0);
      repeat (5) step();
      stall = 3;
      drain();
      rd_cnt = 1'b1;
      step();
      step();
      // randomized traffic
      bubbles = 1'b1;
      rdy_rand = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom % 6 == 0) add_rand_pkt(int'($urandom % N));
         step();
      end
      drain();
      // reset in PAYLOAD
      bubbles = 1'b0;
      rdy_rand = 1'b0;
      add_pkt(1, 8, 1, 8'h80);
      add_pkt(2, 5, 1, 8'h01);
      begin
         int c;
         c = 0;
         while (!(m_cur >= 0 && m_rem < 4) && c < 100) begin
            step();
            c++;
         end
         if (c >= 100) chk("reach_payload_timeout", 64'(c), 64'(0));
      end
      do_rst = 1'b1;
      step();
      for (int q = N - 1; q >= 0; q--) add_pkt(q, 3 + q, 1, 8'h02);
      drain();
      // counter wrap
      force dut.r_pkt_cnt = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      step();
      release dut.r_pkt_cnt;
      rd_cnt = 1'b1;
      step();
      add_pkt(3, 3, 1, 8'h08);
      drain();
      rd_cnt = 1'b1;
      step();
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/reduce_input_arbiter.md
# reduce_input_arbiter

Packet-granular round-robin arbiter that merges NUM_QUEUES receive queues into the single 64-bit datapath feeding output_port_lookup in the reduce_ring node. Never interleaves words of different packets. Registers every output word, so output_port_lookup sees a clean registered stream. Also sits on the UDP register ring: it exposes a read-only forwarded-packet counter and passes all other register requests through with one cycle of delay.

## Interface
- NUM_QUEUES, 4: input queue count, 2..8.
- DATA_WIDTH, 64: word width.
- CTRL_WIDTH, 8: ctrl width.
- UDP_REG_SRC_WIDTH, 2: register source tag width.
- PKT_CNT_ADDR, 0: `UDP_REG_ADDR_WIDTH`-bit address of the packet counter.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  NUM_QUEUES*DATA_WIDTH  queue i occupies bits [i*64 +: 64].
- in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  queue i occupies bits [i*8 +: 8].
- in_wr  in  NUM_QUEUES  per-queue word valid.
- in_rdy  out  NUM_QUEUES  per-queue accept.
- out_data  out  DATA_WIDTH  to output_port_lookup.
- out_ctrl  out  CTRL_WIDTH  to output_port_lookup.
- out_wr  out  1  output word valid.
- out_rdy  in  1  downstream can take a word.
- reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  register ring.
- reg_addr_in  in  `UDP_REG_ADDR_WIDTH`  register ring.
- reg_data_in  in  `CPCI_NF2_DATA_WIDTH`  register ring.
- reg_src_in  in  UDP_REG_SRC_WIDTH  register ring.
- reg_*_out  out  same widths as the matching reg_*_in  registered copies.

## Operation
- A word transfers on queue i in a cycle where in_wr[i] && in_rdy[i].
- in_rdy[i] = (state != IDLE) && (cur == i) && out_rdy. This is combinational from out_rdy. All other queues see in_rdy = 0.
- State IDLE:
  - Search starts at (last_granted+1) mod NUM_QUEUES.
  - The first queue with in_wr set becomes cur.
  - Go to HDR. No word is accepted in this cycle.
- State HDR (module header words, ctrl != 0):
  - On a transfer with ctrl == 0, go to PAYLOAD.
  - On a transfer with ctrl != 0, stay in HDR.
- State PAYLOAD:
  - On a transfer with ctrl != 0 (EOP; the byte-valid mask), go to IDLE.
  - On EOP, last_granted <= cur and pkt_cnt increments.
- Output register:
  - out_data/out_ctrl <= the transferred word.
  - out_wr <= 1 in the cycle after a transfer, else 0.
- pkt_cnt:
  - Width `CPCI_NF2_DATA_WIDTH`; wraps from 0xFFFFFFFF to 0.
  - Increments only on EOP.
- Register ring, one stage, every cycle:
  - Hit = reg_req_in && !reg_ack_in && reg_addr_in == PKT_CNT_ADDR.
  - On a hit: reg_ack_out <= 1. On a read (rd_wr_L = 1), reg_data_out <= pkt_cnt. Writes are ignored but still acked.
  - All other reg_* outputs copy their inputs unchanged.
  - On a miss, every output copies its input.

## Timing
- Latency: input transfer to out_wr = 1 cycle.
- Packet-to-packet gap: 1 idle cycle, spent in IDLE for grant.
- Peak throughput: 1 word/cycle within a packet.
- out_rdy must already account for one word in flight; output_port_lookup's input FIFO guarantees this.
- Reset, synchronous: values below apply the cycle after reset is sampled high.
  - state = IDLE, cur = 0, last_granted = NUM_QUEUES-1 (so queue 0 has first priority).
  - pkt_cnt = 0.
  - out_wr = 0, out_data = 0, out_ctrl = 0.
  - All reg_*_out = 0.
  - in_rdy = 0.
- Reset mid-packet: the packet in progress is abandoned. The source queue is responsible for its own flush.
- Boundary behaviour:
  - out_rdy low stalls in place. State and cur are held; no words are dropped.
  - Simultaneous EOP and register read of pkt_cnt: the read returns the pre-increment value.
  - A single requesting queue is re-granted after its own IDLE cycle.

## Structure
- A shared package (reduce_ring_pkg) holds:
  - State encodings IDLE = 2'd0, HDR = 2'd1, PAYLOAD = 2'd2.
  - Default widths DATA_WIDTH = 64 and CTRL_WIDTH = 8.
  - Register address constants for the node.
- One sub-module, rr_grant:
  - Inputs: request vector and last_granted.
  - Output: next grant index.
  - Purely combinational, parameterised by NUM_QUEUES.

## Test plan
- Single packet on queue 0 (words ctrl 0xFF, 0x00, 0x00, 0x04) with out_rdy = 1 → identical 4 words on out, each 1 cycle after acceptance; pkt_cnt = 1.
- Queues 0–3 each hold one 3-word packet simultaneously → output packet order 0, 1, 2, 3, never interleaved; 1 idle cycle between packets.
- out_rdy dropped for 3 cycles mid-payload → in_rdy = 0 for those cycles; no word lost or duplicated; the stream resumes on the same queue.
- Reset asserted in PAYLOAD → next cycle: state IDLE, out_wr = 0, pkt_cnt = 0; the next packet arrives from queue 0 first.
- Register read at PKT_CNT_ADDR after 5 packets → reg_ack_out = 1, reg_data_out = 5; a read to another address passes through with reg_ack_out equal to reg_ack_in.
- pkt_cnt preloaded near wrap by forcing 0xFFFFFFFF, then one packet → reads 0.
